// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 16-bit, 4-register CPU.
// Owns the PC and issues one word-aligned request at a time to instruction memory.
// Returned words, tagged with their PC, are queued in a small prefetch FIFO.
// The FIFO feeds decode over a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch. The halt word stops fetching.
module fetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Control state
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic             halt_seen_q, halt_seen_d;
  logic             halted_q, halted_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Prefetch FIFO storage (data only, never reset)
  logic [15:0] pc_mem_q    [DEPTH];
  logic [15:0] instr_mem_q [DEPTH];

  logic rsp_fire;
  logic push;
  logic pop;

  // A slot is only requested while the FIFO has room and nothing is in flight,
  // so a response can always be pushed without an overflow check. The request
  // is also held low while reset is asserted.
  assign imem_req = resetn && !outstanding_q && !halt_seen_q && !halted_q
                    && !redirect && (count_q < DEPTH_C);
  assign imem_addr = fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign halted      = halted_q;

  // Responses arriving with nothing outstanding are stray and ignored.
  assign rsp_fire = imem_rvalid && outstanding_q;
  // A redirect cancels both the push and the pop of its own cycle.
  assign push     = rsp_fire && !drop_q && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;

  // Next-state logic for PC, request tracking, halt flags and FIFO pointers.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halt_seen_d   = halt_seen_q;
    halted_d      = halted_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      fetch_pc_d  = redirect_pc & 16'hFFFE;
      halt_seen_d = 1'b0;
      halted_d    = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      if (rsp_fire) begin
        // The in-flight word lands now and is simply not pushed.
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end else if (outstanding_q) begin
        // The in-flight word belongs to the old path; discard it on arrival.
        drop_d = 1'b1;
      end
    end else begin
      if (imem_req) begin
        req_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 16'd2;
        outstanding_d = 1'b1;
      end

      if (rsp_fire) begin
        outstanding_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else if (imem_rdata == HALT_WORD) begin
          halt_seen_d = 1'b1;
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (instr_mem_q[rd_ptr_q] == HALT_WORD) begin
          halted_d = 1'b1;
        end
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      halt_seen_q   <= 1'b0;
      halted_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halt_seen_q   <= halt_seen_d;
      halted_q      <= halted_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage write: the returned word with the PC it was fetched from.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run.
// The reference model treats fetch as a stream of consecutive PCs per redirect,
// together with a simple memory whose words come from a hash of the address.
module tb_fetch_unit;

  localparam int          DEPTH     = 4;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  always #5 clock = ~clock;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clock(clock), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory model
  logic [15:0] mem_ovr [int];
  bit          rand_halts = 1'b0;
  bit          pend = 1'b0;
  bit          stale = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          pend_wait = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          spur_pct = 0;
  bit          late_rv = 1'b0;

  // Fetch-stream model
  logic [15:0] exp_req_pc;
  logic [15:0] exp_pop_pc;
  int          rcv_cnt;
  int          pop_cnt;
  bit          halt_rcvd;
  bit          m_halted;

  // Observation logs
  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [15:0] pop_pc_log[$];
  logic [15:0] pop_ins_log[$];
  int          cyc = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    h = (a * 16'h9E37) ^ 16'h5A5A ^ {a[7:0], a[15:8]};
    if (rand_halts && h[5:0] == 6'd0) return HALT_WORD;
    if (h == HALT_WORD) h = 16'h0001;
    return h;
  endfunction

  function automatic logic [15:0] req_at(input int k);
    return (k < req_log.size()) ? req_log[k] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] pop_pc_at(input int k);
    return (k < pop_pc_log.size()) ? pop_pc_log[k] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] pop_ins_at(input int k);
    return (k < pop_ins_log.size()) ? pop_ins_log[k] : 16'hDEAD;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_pc_log.delete();
    pop_ins_log.delete();
  endtask

  task automatic model_reset();
    exp_req_pc = RESET_PC;
    exp_pop_pc = RESET_PC;
    rcv_cnt    = 0;
    pop_cnt    = 0;
    halt_rcvd  = 1'b0;
    m_halted   = 1'b0;
    pend       = 1'b0;
    stale      = 1'b0;
    pend_wait  = 0;
  endtask

  // One clock cycle: drive memory, check outputs mid-cycle, advance the model.
  // Entered and left 1 time unit after a rising edge.
  task automatic tick();
    logic resp_now, exp_req, pop_now;
    resp_now = pend && (pend_wait == 0);
    if (resp_now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
    end else if (!pend && (late_rv || ($urandom_range(0, 99) < spur_pct))) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'($urandom);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    late_rv = 1'b0;
    #3;

    exp_req = !pend && !halt_rcvd && !m_halted && !redirect && ((rcv_cnt - pop_cnt) < DEPTH);
    chk1("imem_req", imem_req, exp_req);
    if (exp_req) chk16("imem_addr", imem_addr, exp_req_pc);
    chk1("instr_valid", instr_valid, rcv_cnt != pop_cnt);
    chk1("halted", halted, m_halted);
    pop_now = (rcv_cnt != pop_cnt) && instr_ready && !redirect;
    if (pop_now) begin
      chk16("instr_pc", instr_pc, exp_pop_pc);
      chk16("instr", instr, mem_word(exp_pop_pc));
      pop_pc_log.push_back(instr_pc);
      pop_ins_log.push_back(instr);
    end
    if (imem_req) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end

    if (redirect) begin
      if (resp_now) pend = 1'b0;
      stale      = pend;
      exp_req_pc = redirect_pc & 16'hFFFE;
      exp_pop_pc = redirect_pc & 16'hFFFE;
      rcv_cnt    = 0;
      pop_cnt    = 0;
      halt_rcvd  = 1'b0;
      m_halted   = 1'b0;
    end else begin
      if (resp_now) begin
        pend = 1'b0;
        if (!stale) begin
          rcv_cnt++;
          if (mem_word(pend_addr) == HALT_WORD) halt_rcvd = 1'b1;
        end
        stale = 1'b0;
      end
      if (pop_now) begin
        if (mem_word(exp_pop_pc) == HALT_WORD) m_halted = 1'b1;
        pop_cnt++;
        exp_pop_pc = exp_pop_pc + 16'd2;
      end
      if (exp_req) exp_req_pc = exp_req_pc + 16'd2;
    end
    if (pend && pend_wait > 0) pend_wait--;
    if (imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_wait = $urandom_range(lat_lo, lat_hi) - 1;
    end

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    @(posedge clock);
    #2;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk16("rst_imem_addr", imem_addr, RESET_PC);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    model_reset();

    // 1. Sequential fetch, 1-cycle memory, decode always ready
    mem_ovr.delete();
    mem_ovr[0] = 16'h710F;
    mem_ovr[2] = 16'h7207;
    mem_ovr[4] = 16'h26C0;
    lat_lo = 1; lat_hi = 1; spur_pct = 0;
    do_reset();
    instr_ready = 1'b1;
    repeat (8) tick();
    chk16("t1_req0", req_at(0), 16'h0000);
    chk16("t1_req1", req_at(1), 16'h0002);
    chk16("t1_req2", req_at(2), 16'h0004);
    chk16("t1_spacing", (req_cyc.size() > 1) ? 16'(req_cyc[1] - req_cyc[0]) : 16'hDEAD, 16'd2);
    chk16("t1_pc0", pop_pc_at(0), 16'h0000);
    chk16("t1_ins0", pop_ins_at(0), 16'h710F);
    chk16("t1_pc1", pop_pc_at(1), 16'h0002);
    chk16("t1_ins1", pop_ins_at(1), 16'h7207);
    chk16("t1_pc2", pop_pc_at(2), 16'h0004);
    chk16("t1_ins2", pop_ins_at(2), 16'h26C0);

    // 2. Backpressure fills the FIFO, then drains in order
    mem_ovr.delete();
    do_reset();
    instr_ready = 1'b0;
    repeat (12) tick();
    chk16("t2_nreq", 16'(req_log.size()), 16'd4);
    chk16("t2_req3", req_at(3), 16'h0006);
    chk1("t2_req_idle", imem_req, 1'b0);
    instr_ready = 1'b1;
    repeat (14) tick();
    chk16("t2_pop0", pop_pc_at(0), 16'h0000);
    chk16("t2_pop1", pop_pc_at(1), 16'h0002);
    chk16("t2_pop2", pop_pc_at(2), 16'h0004);
    chk16("t2_pop3", pop_pc_at(3), 16'h0006);
    chk16("t2_resume", req_at(4), 16'h0008);

    // 3. Redirect while a 3-cycle request is outstanding
    do_reset();
    lat_lo = 3; lat_hi = 3;
    instr_ready = 1'b1;
    tick();
    clear_logs();
    redirect = 1'b1;
    redirect_pc = 16'h0021;
    tick();
    redirect = 1'b0;
    chk1("t3_flushed", instr_valid, 1'b0);
    repeat (14) tick();
    chk16("t3_req0", req_at(0), 16'h0020);
    chk16("t3_pop0", pop_pc_at(0), 16'h0020);

    // 4. Halt word at 0x12 stops fetch; redirect clears halted
    mem_ovr.delete();
    mem_ovr[16'h12] = HALT_WORD;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    instr_ready = 1'b1;
    repeat (30) tick();
    hits = 0;
    foreach (req_log[i]) if (req_log[i] == 16'h0014) hits++;
    chk16("t4_no_req_14", 16'(hits), 16'd0);
    chk16("t4_last_req", (req_log.size() > 0) ? req_log[$] : 16'hDEAD, 16'h0012);
    chk16("t4_last_pop", (pop_pc_log.size() > 0) ? pop_pc_log[$] : 16'hDEAD, 16'h0012);
    chk1("t4_halted", halted, 1'b1);
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    chk1("t4_unhalt", halted, 1'b0);
    clear_logs();
    repeat (4) tick();
    chk16("t4_restart", req_at(0), 16'h0000);

    // 5. PC wrap from FFFE to 0000
    mem_ovr.delete();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    clear_logs();
    repeat (8) tick();
    chk16("t5_req0", req_at(0), 16'hFFFE);
    chk16("t5_req1", req_at(1), 16'h0000);
    chk16("t5_pop0", pop_pc_at(0), 16'hFFFE);
    chk16("t5_pop1", pop_pc_at(1), 16'h0000);

    // 6. Asynchronous reset with one request outstanding and two entries queued
    do_reset();
    lat_lo = 2; lat_hi = 2;
    instr_ready = 1'b0;
    for (int i = 0; i < 40 && !(rcv_cnt == 2 && pend); i++) tick();
    chk1("t6_setup", rcv_cnt == 2 && pend, 1'b1);
    chk1("t6_pre_valid", instr_valid, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk1("t6_valid_clr", instr_valid, 1'b0);
    chk1("t6_req_clr", imem_req, 1'b0);
    chk1("t6_halted_clr", halted, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    clear_logs();
    late_rv = 1'b1;
    repeat (6) tick();
    chk16("t6_first_req", req_at(0), RESET_PC);

    // Randomized run with latency, backpressure, stray responses, halts and redirects
    mem_ovr.delete();
    rand_halts = 1'b1;
    lat_lo = 1; lat_hi = 4; spur_pct = 25;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 99) < ((m_halted || halt_rcvd) ? 30 : 3));
      redirect_pc = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                : 16'($urandom);
      tick();
    end
    redirect = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
